game_sprite_scheduler: RTL

//  Sequences one game_sprite_top instance: launches the sprite at a pseudo-random X,

---
 rtl/game_sprite_scheduler_pkg.sv | 25 ++
 rtl/game_lfsr.sv | 37 +++
 rtl/game_sprite_scheduler.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/game_sprite_scheduler_pkg.sv
// Shared encodings and constants for the sprite scheduler and the game FSM.
package game_sprite_scheduler_pkg;

    // Scheduler states; the numeric values are visible to the game FSM and to debug.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_SETV = 3'd2,
        ST_RUN  = 3'd3,
        ST_WAIT = 3'd4
    } sched_state_e;

    // 16-bit Fibonacci LFSR, taps 16,14,13,11 expressed as a mask on bits 15,13,12,10.
    localparam int unsigned LFSR_WIDTH = 16;
    localparam logic [15:0] LFSR_TAPS  = 16'hB400;

    // Launch counter width; it wraps naturally at 255 -> 0.
    localparam int unsigned LAUNCH_COUNT_WIDTH = 8;

    // Bits needed for a counter holding 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/game_lfsr.sv
// Free-running Fibonacci LFSR shifting left, feedback is the XOR of the tapped bits.
module game_lfsr #(
    parameter int unsigned            WIDTH     = 16,
    parameter int unsigned            OUT_WIDTH = 16,
    parameter logic [WIDTH-1:0]       SEED      = '1,
    parameter logic [WIDTH-1:0]       TAPS      = WIDTH'(16'hB400)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    output logic [OUT_WIDTH-1:0] value
);

    logic [WIDTH-1:0] lfsr_q;
    logic [WIDTH-1:0] lfsr_d;

    // Next LFSR value: shift in the parity of the tapped bits when enabled.
    always_comb begin
        lfsr_d = lfsr_q;
        if (enable) begin
            lfsr_d = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
        end
    end

    // LFSR register, restarts from the seed on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // Only the low bits are consumed by the scheduler.
    assign value = lfsr_q[OUT_WIDTH-1:0];

endmodule

// File: rtl/game_sprite_scheduler.sv
// Sequences one sprite: launch at a pseudo-random X, load speed, pace moves to the
// frame tick, detect exit/collision and relaunch after a frame delay.
//
// Interface: sprite_write_xy, sprite_write_dxy and sprite_enable_update are single-cycle
// strobes with no ready/backpressure; the sprite must accept them in the cycle they are
// high, and at most one of them is high in any cycle. Data outputs hold between strobes.
module game_sprite_scheduler
    import game_sprite_scheduler_pkg::*;
#(
    parameter int unsigned          X_WIDTH         = 10,
    parameter int unsigned          Y_WIDTH         = 10,
    parameter int unsigned          DX_WIDTH        = 2,
    parameter int unsigned          DY_WIDTH        = 2,
    parameter logic [X_WIDTH-1:0]   START_X_MASK    = 10'h1ff,
    parameter logic [Y_WIDTH-1:0]   START_Y         = '0,
    parameter logic [DX_WIDTH-1:0]  DX_RIGHT        = 2'b01,
    parameter logic [DX_WIDTH-1:0]  DX_LEFT         = 2'b11,
    parameter logic [DY_WIDTH-1:0]  START_DY        = 2'b01,
    parameter int unsigned          UPDATE_DIV      = 2,
    parameter int unsigned          RELAUNCH_FRAMES = 30,
    parameter logic [15:0]          LFSR_SEED       = 16'hACE1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          launch,
    input  logic                          stop,
    input  logic                          auto_relaunch,
    input  logic                          frame_tick,
    input  logic                          sprite_within_screen,
    input  logic                          collision,
    output logic                          sprite_write_xy,
    output logic                          sprite_write_dxy,
    output logic [X_WIDTH-1:0]            sprite_write_x,
    output logic [Y_WIDTH-1:0]            sprite_write_y,
    output logic [DX_WIDTH-1:0]           sprite_write_dx,
    output logic [DY_WIDTH-1:0]           sprite_write_dy,
    output logic                          sprite_enable_update,
    output logic                          active,
    output logic [LAUNCH_COUNT_WIDTH-1:0] launch_count,
    output logic [2:0]                    dbg_state
);

    localparam int DIV_W = cnt_width(int'(UPDATE_DIV));
    localparam int DLY_W = cnt_width(int'(RELAUNCH_FRAMES) + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(UPDATE_DIV - 1);
    localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'(RELAUNCH_FRAMES);
    localparam logic [DLY_W-1:0] DLY_ONE  = DLY_W'(1);

    sched_state_e                  state_q, state_d;
    logic [DIV_W-1:0]              div_q, div_d;
    logic [DLY_W-1:0]              delay_q, delay_d;
    logic                          moved_q, moved_d;
    logic                          update_fire;

    logic                          write_xy_q, write_xy_d;
    logic                          write_dxy_q, write_dxy_d;
    logic                          enable_update_q, enable_update_d;
    logic                          active_q, active_d;
    logic [X_WIDTH-1:0]            write_x_q, write_x_d;
    logic [Y_WIDTH-1:0]            write_y_q, write_y_d;
    logic [DX_WIDTH-1:0]           write_dx_q, write_dx_d;
    logic [DY_WIDTH-1:0]           write_dy_q, write_dy_d;
    logic [LAUNCH_COUNT_WIDTH-1:0] launch_count_q, launch_count_d;

    logic [X_WIDTH-1:0]            lfsr_value;

    game_lfsr #(
        .WIDTH     (LFSR_WIDTH),
        .OUT_WIDTH (X_WIDTH),
        .SEED      (LFSR_SEED),
        .TAPS      (LFSR_TAPS)
    ) u_lfsr (
        .clk    (clk),
        .rst    (reset),
        .enable (1'b1),
        .value  (lfsr_value)
    );

    // Next state plus divider, relaunch delay and moved flag; stop overrides everything.
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        delay_d     = delay_q;
        moved_d     = moved_q;
        update_fire = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (launch) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d = ST_SETV;
            end
            ST_SETV: begin
                div_d   = '0;
                moved_d = 1'b0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (frame_tick) begin
                    if (div_q == DIV_LAST) begin
                        div_d       = '0;
                        update_fire = 1'b1;
                        moved_d     = 1'b1;
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end
                // Exit is only trusted once the sprite has moved at least once.
                if (collision || (!sprite_within_screen && moved_q)) begin
                    state_d = ST_WAIT;
                    delay_d = DLY_LOAD;
                end
            end
            ST_WAIT: begin
                if (frame_tick) begin
                    if (delay_q <= DLY_ONE) begin
                        delay_d = '0;
                        state_d = auto_relaunch ? ST_LOAD : ST_IDLE;
                    end else begin
                        delay_d = delay_q - DLY_ONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (stop) begin
            state_d     = ST_IDLE;
            update_fire = 1'b0;
        end
    end

    // Registered outputs derived from the state being entered, so they line up with it.
    always_comb begin
        write_xy_d      = (state_d == ST_LOAD);
        write_dxy_d     = (state_d == ST_SETV);
        enable_update_d = update_fire && (state_d == ST_RUN);
        active_d        = (state_d == ST_LOAD) || (state_d == ST_SETV) || (state_d == ST_RUN);
        write_x_d       = write_x_q;
        write_y_d       = write_y_q;
        write_dx_d      = write_dx_q;
        write_dy_d      = write_dy_q;
        launch_count_d  = launch_count_q;

        if (state_d == ST_LOAD) begin
            write_x_d      = lfsr_value & START_X_MASK;
            write_y_d      = START_Y;
            launch_count_d = launch_count_q + 1'b1;
        end
        if (state_d == ST_SETV) begin
            write_dx_d = lfsr_value[0] ? DX_RIGHT : DX_LEFT;
            write_dy_d = START_DY;
        end
    end

    // FSM state, counters and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            div_q           <= '0;
            delay_q         <= '0;
            moved_q         <= 1'b0;
            write_xy_q      <= 1'b0;
            write_dxy_q     <= 1'b0;
            enable_update_q <= 1'b0;
            active_q        <= 1'b0;
            write_x_q       <= '0;
            write_y_q       <= '0;
            write_dx_q      <= '0;
            write_dy_q      <= '0;
            launch_count_q  <= '0;
        end else begin
            state_q         <= state_d;
            div_q           <= div_d;
            delay_q         <= delay_d;
            moved_q         <= moved_d;
            write_xy_q      <= write_xy_d;
            write_dxy_q     <= write_dxy_d;
            enable_update_q <= enable_update_d;
            active_q        <= active_d;
            write_x_q       <= write_x_d;
            write_y_q       <= write_y_d;
            write_dx_q      <= write_dx_d;
            write_dy_q      <= write_dy_d;
            launch_count_q  <= launch_count_d;
        end
    end

    assign sprite_write_xy      = write_xy_q;
    assign sprite_write_dxy     = write_dxy_q;
    assign sprite_enable_update = enable_update_q;
    assign sprite_write_x       = write_x_q;
    assign sprite_write_y       = write_y_q;
    assign sprite_write_dx      = write_dx_q;
    assign sprite_write_dy      = write_dy_q;
    assign active               = active_q;
    assign launch_count         = launch_count_q;
    assign dbg_state            = state_q;

endmodule
